// File: rtl/ram_loader.sv
// Framed serial-to-RAM loader: owns the RAM write port while a frame is in progress, otherwise passes CPU accesses through.
// Optional trailing checksum byte is enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter int         ADDR_WIDTH     = 14,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_w_en,
  input  logic [7:0]            cpu_din,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_w_en,
  output logic [7:0]            ram_din,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef RAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, AH, AL, LH, LL, DATA, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, AH, AL, LH, LL, DATA} state_t;
`endif

  state_t                state_reg;
  logic [7:0]            addr_hi_reg;
  logic [7:0]            len_hi_reg;
  logic [15:0]           count_reg;
  logic [ADDR_WIDTH-1:0] pointer_reg;
  logic [TW-1:0]         timer_reg;
  logic                  ld_we_reg;
  logic [ADDR_WIDTH-1:0] ld_addr_reg;
  logic [7:0]            ld_din_reg;
  logic [15:0]           len_next;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_reg;
  logic [7:0]            sum_next;
  assign sum_next = sum_reg + rx_data;
`endif

  assign len_next = {len_hi_reg, rx_data};

  // Loader drives the RAM for the whole busy window, so CPU writes during it are dropped.
  assign ram_address = busy ? ld_addr_reg : cpu_address;
  assign ram_w_en    = busy ? ld_we_reg   : cpu_w_en;
  assign ram_din     = busy ? ld_din_reg  : cpu_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      addr_hi_reg <= '0;
      len_hi_reg  <= '0;
      count_reg   <= '0;
      pointer_reg <= '0;
      timer_reg   <= '0;
      ld_we_reg   <= 1'b0;
      ld_addr_reg <= '0;
      ld_din_reg  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_reg     <= '0;
`endif
    end else begin
      ld_we_reg <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      // busy lingers through the done/error cycle so the final write is still steered.
      if (done || error) busy <= 1'b0;

      if (state_reg == IDLE || rx_valid) timer_reg <= '0;
      else                               timer_reg <= timer_reg + 1'b1;

      if (state_reg != IDLE && !rx_valid && timer_reg == TIMER_LAST) begin
        error     <= 1'b1;
        state_reg <= IDLE;
      end else if (rx_valid) begin
`ifdef RAM_LOADER_CHECKSUM_EN
        if (state_reg != IDLE) sum_reg <= sum_next;
`endif
        case (state_reg)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state_reg <= AH;
              busy      <= 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
              sum_reg   <= '0;
`endif
            end
          end
          AH: begin
            addr_hi_reg <= rx_data;
            state_reg   <= AL;
          end
          AL: begin
            pointer_reg <= ADDR_WIDTH'({addr_hi_reg, rx_data});
            state_reg   <= LH;
          end
          LH: begin
            len_hi_reg <= rx_data;
            state_reg  <= LL;
          end
          LL: begin
            count_reg <= len_next;
            if (len_next != 16'd0) begin
              state_reg <= DATA;
            end else begin
`ifdef RAM_LOADER_CHECKSUM_EN
              state_reg <= CSUM;
`else
              done      <= 1'b1;
              state_reg <= IDLE;
`endif
            end
          end
          DATA: begin
            ld_we_reg   <= 1'b1;
            ld_addr_reg <= pointer_reg;
            ld_din_reg  <= rx_data;
            pointer_reg <= pointer_reg + 1'b1;
            count_reg   <= count_reg - 16'd1;
            if (count_reg == 16'd1) begin
`ifdef RAM_LOADER_CHECKSUM_EN
              state_reg <= CSUM;
`else
              done      <= 1'b1;
              state_reg <= IDLE;
`endif
            end
          end
`ifdef RAM_LOADER_CHECKSUM_EN
          CSUM: begin
            if (sum_next == 8'h00) done  <= 1'b1;
            else                   error <= 1'b1;
            state_reg <= IDLE;
          end
`endif
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: passthrough vector table plus hand-written frame, wrap, timeout and reset sequences.
// Works with or without RAM_LOADER_CHECKSUM_EN defined.
module tb_ram_loader;
  localparam int AW = 14;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic          cpu_w_en = 1'b0;
  logic [7:0]    cpu_din = '0;
  logic [AW-1:0] ram_address;
  logic          ram_w_en;
  logic [7:0]    ram_din;
  logic          busy, done, error;

  ram_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_address(cpu_address), .cpu_w_en(cpu_w_en), .cpu_din(cpu_din),
    .ram_address(ram_address), .ram_w_en(ram_w_en), .ram_din(ram_din),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  int wcount = 0, dcount = 0, ecount = 0;
  int total = 0, bad = 0;

  // RAM model and pulse counters observe the DUT outputs at each rising edge.
  always @(posedge clk) begin
    if (ram_w_en) begin
      mem[ram_address] = ram_din;
      wcount = wcount + 1;
    end
    if (done)  dcount = dcount + 1;
    if (error) ecount = ecount + 1;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    din;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [7:0]    exp_din;
  } pt_vec_t;

  pt_vec_t pt [4];

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends header and up to 3 data bytes; in checksum builds appends a correct or a bad CSUM.
  task automatic send_frame(input logic [15:0] a, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic bad_csum);
    logic [7:0] s;
    logic [15:0] len;
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    len = 16'(n);
    s = a[15:8] + a[7:0] + len[15:8] + len[7:0];
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < n; i++) begin
      s = s + d[i];
      send_byte(d[i]);
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? 8'h00 : (8'h00 - s));
`else
    if (bad_csum) s = s;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0c, e0c, k;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;

    pt[0] = '{14'h0000, 1'b0, 8'h00, 14'h0000, 1'b0, 8'h00};
    pt[1] = '{14'h3FFF, 1'b1, 8'hC3, 14'h3FFF, 1'b1, 8'hC3};
    pt[2] = '{14'h1555, 1'b0, 8'h5A, 14'h1555, 1'b0, 8'h5A};
    pt[3] = '{14'h2AAA, 1'b1, 8'hA5, 14'h2AAA, 1'b1, 8'hA5};

    // Reset state
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    #3 rst_n = 1'b1;
    tick(2);

    // Idle passthrough vectors
    for (int i = 0; i < 4; i++) begin
      cpu_address = pt[i].addr;
      cpu_w_en    = pt[i].we;
      cpu_din     = pt[i].din;
      #1;
      check($sformatf("pt%0d_addr", i), int'(ram_address), int'(pt[i].exp_addr));
      check($sformatf("pt%0d_we", i),   int'(ram_w_en),    int'(pt[i].exp_we));
      check($sformatf("pt%0d_din", i),  int'(ram_din),     int'(pt[i].exp_din));
      tick(1);
    end
    cpu_w_en = 1'b0;
    tick(1);

    // Basic load with CPU writes held off while busy
    w0 = wcount; d0c = dcount; e0c = ecount;
    cpu_address = 14'h1234; cpu_din = 8'hEE;
    send_byte(8'hA5);
    check("busy_after_sync", busy, 1);
    cpu_w_en = 1'b1;
    send_byte(8'h02); send_byte(8'h80); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef RAM_LOADER_CHECKSUM_EN
    send_byte(8'h15);
`endif
    cpu_w_en = 1'b0;
    check("last_cycle_busy", busy, 1);
    check("last_cycle_done", done, 1);
    tick(1);
    check("busy_dropped", busy, 0);
    tick(1);
    check("basic_m280", mem[14'h0280], 8'h11);
    check("basic_m281", mem[14'h0281], 8'h22);
    check("basic_m282", mem[14'h0282], 8'h33);
    check("basic_writes", wcount - w0, 3);
    check("basic_done", dcount - d0c, 1);
    check("basic_err", ecount - e0c, 0);
    check("cpu_dropped", mem[14'h1234], 8'h00);

    // Address wrap
    w0 = wcount; d0c = dcount;
    send_frame(16'h3FFF, 2, 8'hAA, 8'hBB, 8'h00, 1'b0);
    tick(2);
    check("wrap_m3fff", mem[14'h3FFF], 8'hAA);
    check("wrap_m0000", mem[14'h0000], 8'hBB);
    check("wrap_writes", wcount - w0, 2);
    check("wrap_done", dcount - d0c, 1);

    // Zero length frame
    w0 = wcount; d0c = dcount;
    send_frame(16'h0010, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(2);
    check("zero_writes", wcount - w0, 0);
    check("zero_done", dcount - d0c, 1);
    check("zero_busy", busy, 0);

    // Timeout after A5 02 00, then a stray byte is ignored
    e0c = ecount; d0c = dcount;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (error) begin k = c; break; end
    end
    check("timeout_cycle", k, TO);
    check("timeout_busy_in_pulse", busy, 1);
    tick(1);
    check("timeout_busy_after", busy, 0);
    send_byte(8'h55);
    tick(2);
    check("timeout_stray_busy", busy, 0);
    check("timeout_errors", ecount - e0c, 1);
    check("timeout_no_done", dcount - d0c, 0);

    // Byte arriving exactly at expiry wins
    e0c = ecount; d0c = dcount;
    send_byte(8'hA5);
    tick(TO - 1);
    send_frame_tail();
    tick(2);
    check("expiry_race_err", ecount - e0c, 0);
    check("expiry_race_done", dcount - d0c, 1);

`ifdef RAM_LOADER_CHECKSUM_EN
    // Bad checksum: data written, error instead of done
    w0 = wcount; d0c = dcount; e0c = ecount;
    send_frame(16'h0280, 3, 8'h11, 8'h22, 8'h33, 1'b1);
    tick(2);
    check("csum_writes", wcount - w0, 3);
    check("csum_err", ecount - e0c, 1);
    check("csum_done", dcount - d0c, 0);
`endif

    // Asynchronous reset mid-frame with a pending loader write
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    cpu_address = 14'h0ABC; cpu_din = 8'h5A; cpu_w_en = 1'b0;
    send_byte(8'h77);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_we_cancel", ram_w_en, 0);
    check("arst_addr", int'(ram_address), 14'h0ABC);
    cpu_w_en = 1'b1;
    #1;
    check("arst_we_pass", ram_w_en, 1);
    check("arst_din", ram_din, 8'h5A);
    cpu_w_en = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("arst_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Rest of a zero-length frame to 0x0010, sent after SYNC already went out.
  task automatic send_frame_tail();
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
`ifdef RAM_LOADER_CHECKSUM_EN
    send_byte(8'hF0);
`endif
  endtask

endmodule
